// File: rtl/relay_bus_pkg.sv
// Shared types and sizes for the register-unit data-bus protocol.
package relay_bus_pkg;

  localparam int N    = 8;
  localparam int NREG = 8;

  typedef enum logic [2:0] {
    REG_A  = 3'd0,
    REG_B  = 3'd1,
    REG_C  = 3'd2,
    REG_D  = 3'd3,
    REG_M1 = 3'd4,
    REG_M2 = 3'd5,
    REG_X  = 3'd6,
    REG_Y  = 3'd7
  } reg_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } mov_state_t;

endpackage

// File: rtl/bus_phase_timer.sv
// Phase timer: counts cycles spent in a timed phase and flags the last one.
module bus_phase_timer #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Count up while the phase is active; restart from zero whenever a phase begins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = i_en && (r_count == (i_limit - 1'b1));

endmodule

// File: rtl/mov8_bus_driver.sv
// Drives one register-to-register move: select source onto the bus, let it
// settle, pulse the destination load, hold, then release and report done.
module mov8_bus_driver
  import relay_bus_pkg::*;
#(
  parameter int N      = relay_bus_pkg::N,
  parameter int NREG   = relay_bus_pkg::NREG,
  parameter int SETTLE = 2,
  parameter int HOLD   = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [2:0]              i_src_idx,
  input  logic [2:0]              i_dst_idx,
  input  logic [NREG-1:0][N-1:0]  i_src_data,
  output logic [N-1:0]            o_bus_data,
  output logic                    o_bus_drive,
  output logic [NREG-1:0]         o_sel,
  output logic [NREG-1:0]         o_ld,
  output logic [NREG-1:0]         o_led_sel,
  output logic [NREG-1:0]         o_led_ld,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int MAXPH = (SETTLE > HOLD) ? SETTLE : HOLD;
  localparam int PW    = $clog2(MAXPH + 1);

  mov_state_t    r_state;
  logic [2:0]    r_dst;
  logic          w_counting;
  logic          w_clear;
  logic          w_tc;
  logic [PW-1:0] w_limit;

  assign w_counting = (r_state == ST_SELECT) || (r_state == ST_RELEASE);
  assign w_clear    = !w_counting || w_tc;
  assign w_limit    = (r_state == ST_RELEASE) ? PW'(HOLD) : PW'(SETTLE);

  bus_phase_timer #(.W(PW)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_clear),
    .i_en    (w_counting),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  // Move sequencer; outputs are set on the edge that enters each state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_dst       <= '0;
      o_bus_data  <= '0;
      o_bus_drive <= 1'b0;
      o_sel       <= '0;
      o_ld        <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_state     <= ST_SELECT;
            r_dst       <= i_dst_idx;
            o_bus_data  <= i_src_data[i_src_idx];
            o_bus_drive <= 1'b1;
            o_sel       <= NREG'(1) << i_src_idx;
            o_busy      <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SELECT: begin
          if (w_tc) begin
            r_state <= ST_STROBE;
            o_ld    <= NREG'(1) << r_dst;
          end
        end
        ST_STROBE: begin
          o_ld <= '0;
          if (HOLD > 0) begin
            r_state <= ST_RELEASE;
          end else begin
            r_state     <= ST_DONE;
            o_bus_data  <= '0;
            o_bus_drive <= 1'b0;
            o_sel       <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (w_tc) begin
            r_state     <= ST_DONE;
            o_bus_data  <= '0;
            o_bus_drive <= 1'b0;
            o_sel       <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_led_sel = o_sel;
  assign o_led_ld  = o_ld;

endmodule

// File: tb/tb_mov8_bus_driver.sv
// Bench for mov8_bus_driver: a default build (SETTLE=2, HOLD=1) and a fast
// build (SETTLE=1, HOLD=0) share one stimulus stream and one timing model.
module tb_mov8_bus_driver;
  import relay_bus_pkg::*;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic start = 1'b0;
  logic [2:0] srcIdx = '0;
  logic [2:0] dstIdx = '0;
  logic [7:0][7:0] srcData = '0;

  logic [7:0] bd0, sel0, ld0, ls0, ll0;
  logic dr0, busy0, done0;
  logic [7:0] bd1, sel1, ld1, ls1, ll1;
  logic dr1, busy1, done1;

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;
  bit checkEn = 1'b0;

  // Model state per DUT: the cycle the current move was accepted and what it latched.
  int setArr[2] = '{2, 1};
  int holdArr[2] = '{1, 0};
  int t0[2] = '{0, 0};
  bit act[2] = '{1'b0, 1'b0};
  logic [7:0] mData[2];
  logic [2:0] mSrc[2];
  logic [2:0] mDst[2];

  mov8_bus_driver #(.N(8), .NREG(8), .SETTLE(2), .HOLD(1)) dut0 (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_src_idx(srcIdx),
    .i_dst_idx(dstIdx), .i_src_data(srcData), .o_bus_data(bd0),
    .o_bus_drive(dr0), .o_sel(sel0), .o_ld(ld0), .o_led_sel(ls0),
    .o_led_ld(ll0), .o_busy(busy0), .o_done(done0)
  );

  mov8_bus_driver #(.N(8), .NREG(8), .SETTLE(1), .HOLD(0)) dut1 (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_src_idx(srcIdx),
    .i_dst_idx(dstIdx), .i_src_data(srcData), .o_bus_data(bd1),
    .o_bus_drive(dr1), .o_sel(sel1), .o_ld(ld1), .o_led_sel(ls1),
    .o_led_ld(ll1), .o_busy(busy1), .o_done(done1)
  );

  // Free-running clock and a cycle index that advances on each rising edge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Outputs of a move accepted at t0: driven for cycles 1..S+1+H after it,
  // load in cycle S+1, done in cycle S+H+2.
  task automatic checkDut(input int d, input logic [7:0] bd, input logic dr,
                          input logic [7:0] sel, input logic [7:0] ld,
                          input logic [7:0] ls, input logic [7:0] ll,
                          input logic busy, input logic done);
    int k;
    bit on;
    logic [7:0] eSel, eLd, eData;
    k = cyc - t0[d];
    on = act[d] && (k >= 1) && (k <= setArr[d] + 1 + holdArr[d]);
    eSel = on ? (8'h01 << mSrc[d]) : 8'h00;
    eData = on ? mData[d] : 8'h00;
    eLd = (act[d] && k == setArr[d] + 1) ? (8'h01 << mDst[d]) : 8'h00;
    checkOutput($sformatf("d%0d.bus_data", d), 32'(bd), 32'(eData));
    checkOutput($sformatf("d%0d.bus_drive", d), 32'(dr), 32'(on));
    checkOutput($sformatf("d%0d.sel", d), 32'(sel), 32'(eSel));
    checkOutput($sformatf("d%0d.ld", d), 32'(ld), 32'(eLd));
    checkOutput($sformatf("d%0d.led_sel", d), 32'(ls), 32'(eSel));
    checkOutput($sformatf("d%0d.led_ld", d), 32'(ll), 32'(eLd));
    checkOutput($sformatf("d%0d.busy", d), 32'(busy), 32'(on));
    checkOutput($sformatf("d%0d.done", d),
                32'(done), 32'(act[d] && k == setArr[d] + holdArr[d] + 2));
  endtask

  // Advance the model by one cycle using this cycle's inputs.
  task automatic modelUpdate();
    for (int d = 0; d < 2; d++) begin
      if (!rstN) begin
        act[d] = 1'b0;
      end else begin
        if (act[d] && (cyc - t0[d]) >= setArr[d] + holdArr[d] + 2) act[d] = 1'b0;
        if (!act[d] && start) begin
          act[d] = 1'b1;
          t0[d] = cyc;
          mData[d] = srcData[srcIdx];
          mSrc[d] = srcIdx;
          mDst[d] = dstIdx;
        end
      end
    end
  endtask

  // Mid-cycle compare of both DUTs against the model, then step the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkDut(0, bd0, dr0, sel0, ld0, ls0, ll0, busy0, done0);
      checkDut(1, bd1, dr1, sel1, ld1, ls1, ll1, busy1, done1);
    end
    modelUpdate();
  end

  // Move to the next cycle and set that cycle's control inputs.
  task automatic applyStimulus(input logic st, input logic [2:0] s, input logic [2:0] dd);
    @(posedge clk);
    #1;
    start = st;
    srcIdx = s;
    dstIdx = dd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 3'd0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, ".d0"}, {bd0, sel0, ld0, 5'd0, dr0, busy0, done0}, 32'd0);
  endtask

  // Directed scenarios with literal expectations, then a randomized run.
  initial begin
    int doneCount;
    for (int i = 0; i < 8; i++) srcData[i] = 8'($urandom);
    idle(2);
    checkEn = 1'b1;
    @(negedge clk);
    checkAllZero("resetState");
    checkOutput("resetState.d1", {bd1, sel1, ld1, 5'd0, dr1, busy1, done1}, 32'd0);
    #1 rstN = 1'b1;
    idle(2);

    // Move B -> C carrying A5, with the source changing mid-move.
    applyStimulus(1'b1, 3'(REG_B), 3'(REG_C));
    srcData[1] = 8'hA5;
    applyStimulus(1'b0, 3'd0, 3'd0);
    @(negedge clk);
    checkOutput("mvB.c1.sel", 32'(sel0), 32'h02);
    checkOutput("mvB.c1.data", 32'(bd0), 32'hA5);
    applyStimulus(1'b0, 3'd0, 3'd0);
    srcData[1] = 8'h3C;
    @(negedge clk);
    checkOutput("mvB.c2.ld", 32'(ld0), 32'h00);
    applyStimulus(1'b0, 3'd0, 3'd0);
    @(negedge clk);
    checkOutput("mvB.c3.ld", 32'(ld0), 32'h04);
    applyStimulus(1'b0, 3'd0, 3'd0);
    @(negedge clk);
    checkOutput("mvB.c4.data", 32'(bd0), 32'hA5);
    checkOutput("mvB.c4.ld", 32'(ld0), 32'h00);
    applyStimulus(1'b0, 3'd0, 3'd0);
    @(negedge clk);
    checkOutput("mvB.c5.done", 32'(done0), 32'd1);
    applyStimulus(1'b0, 3'd0, 3'd0);
    @(negedge clk);
    checkAllZero("mvB.c6");
    idle(3);

    // Self-move on X with all-ones data, checked on the fast build.
    applyStimulus(1'b1, 3'(REG_X), 3'(REG_X));
    srcData[6] = 8'hFF;
    applyStimulus(1'b0, 3'd0, 3'd0);
    @(negedge clk);
    checkOutput("mvX.c1.sel", 32'(sel1), 32'h40);
    checkOutput("mvX.c1.ld", 32'(ld1), 32'h00);
    applyStimulus(1'b0, 3'd0, 3'd0);
    @(negedge clk);
    checkOutput("mvX.c2.sel", 32'(sel1), 32'h40);
    checkOutput("mvX.c2.ld", 32'(ld1), 32'h40);
    checkOutput("mvX.c2.data", 32'(bd1), 32'hFF);
    applyStimulus(1'b0, 3'd0, 3'd0);
    @(negedge clk);
    checkOutput("mvX.c3.done", 32'(done1), 32'd1);
    checkOutput("mvX.c3.sel", 32'(sel1), 32'h00);
    idle(6);

    // Start held high: back-to-back A -> D moves every five cycles.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 3'(REG_A), 3'(REG_D));
      if (i == 5) begin
        @(negedge clk);
        checkOutput("b2b.c5.done", 32'(done0), 32'd1);
        checkOutput("b2b.c5.busy", 32'(busy0), 32'd0);
      end
      if (i == 6) begin
        @(negedge clk);
        checkOutput("b2b.c6.sel", 32'(sel0), 32'h01);
      end
    end
    idle(8);

    // Reset pulse in cycle 2 aborts the move with no load or done afterwards.
    applyStimulus(1'b1, 3'(REG_C), 3'(REG_M2));
    applyStimulus(1'b0, 3'd0, 3'd0);
    applyStimulus(1'b0, 3'd0, 3'd0);
    rstN = 1'b0;
    applyStimulus(1'b0, 3'd0, 3'd0);
    rstN = 1'b1;
    for (int i = 3; i < 9; i++) begin
      @(negedge clk);
      checkAllZero($sformatf("abort.c%0d", i));
      applyStimulus(1'b0, 3'd0, 3'd0);
    end
    idle(2);

    // Extra start pulses during a move are dropped; one done at cycle 5.
    doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i == 0 || i == 2 || i == 3), 3'(REG_M1), 3'(REG_B));
      @(negedge clk);
      if (done0) doneCount++;
      if (i == 5) checkOutput("ignore.c5.done", 32'(done0), 32'd1);
    end
    checkOutput("ignore.doneCount", 32'(doneCount), 32'd1);
    idle(8);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      applyStimulus(($urandom_range(0, 2) == 0), 3'($urandom), 3'($urandom));
      rstN = ($urandom_range(0, 99) != 0);
      srcData[$urandom_range(0, 7)] = 8'($urandom);
    end
    rstN = 1'b1;
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mov8_bus_driver.md
# mov8_bus_driver

Transmitter side of the register-unit data-bus protocol: executes one 8-bit register-to-register move by selecting a source register onto the data bus, letting the bus settle, pulsing the destination load strobe, then releasing the bus. It sits between the sequencer and the register unit. It produces the per-register `sel*` and `ld*` lines and their LED mirrors. Destination registers capture `data_bus.data` while their `ld` is high.

## Interface
Parameters:
- `N`, 8, data bus width
- `NREG`, 8, register count (A,B,C,D,M1,M2,X,Y)
- `SETTLE`, 2, cycles the bus is driven before the load strobe; legal range ≥1
- `HOLD`, 1, cycles the bus stays driven after the strobe; legal range ≥0

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  request a move; accepted only when `busy`=0
- `src_idx`  in  3  source register index, sampled on accept
- `dst_idx`  in  3  destination register index, sampled on accept
- `src_data`  in  NREG×N  current contents of all registers
- `bus_data`  out  N  value driven onto the data bus
- `bus_drive`  out  1  bus is being driven
- `sel`  out  NREG  one-hot source select
- `ld`  out  NREG  one-hot destination load strobe
- `led_sel`  out  NREG  mirror of `sel`
- `led_ld`  out  NREG  mirror of `ld`
- `busy`  out  1  move in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SELECT, STROBE, RELEASE, DONE.
- IDLE: on `start`=1, latch `src_idx`, `dst_idx`, and `src_data[src_idx]` into internal registers, then go to SELECT.
- SELECT: lasts SETTLE cycles. `sel[src]`=1, `bus_drive`=1, `bus_data`=latched value. After SETTLE cycles go to STROBE.
- STROBE: lasts exactly 1 cycle. `sel` and the bus stay as in SELECT, and `ld[dst]`=1. Go to RELEASE if HOLD>0, otherwise go to DONE.
- RELEASE: lasts HOLD cycles. `sel` and the bus stay as in SELECT, and `ld`=0. Then go to DONE.
- DONE: lasts 1 cycle. `done`=1, `busy`=0, and `sel`, `ld`, `bus_drive` are all 0, with `bus_data`=0.
  - If `start`=1 in this cycle, the new move is accepted and the next state is SELECT.
  - Otherwise the next state is IDLE.
- `bus_data` is 0 whenever `bus_drive`=0. This models the relay bus pulling low when undriven.
- Data is snapshotted on accept. Changes to `src_data` during a move do not affect `bus_data`.
- `src_idx`==`dst_idx` is legal. The register reloads its own value, and `sel` and `ld` for that register are both high during STROBE.
- `start` while `busy`=1 is ignored. It is neither queued nor an error.
- `led_sel` and `led_ld` are combinational copies of `sel` and `ld`.
- All outputs are registered, except the LED mirrors.
- Reset:
  - Every output resets to 0 and the state goes to IDLE.
  - Reset asserted mid-move aborts the move at that clock edge. No `ld` pulse and no `done` pulse follow it.

## Timing
- `start` is accepted at edge T and `busy` rises at T+1.
- `sel` and the bus are high for cycles T+1 through T+SETTLE+1+HOLD.
- `ld` is high for the single cycle T+SETTLE+1.
- `done` is high in cycle T+SETTLE+HOLD+2.
- With the defaults, for a `start` accepted at cycle 0:
  - cycles 1–2: SELECT
  - cycle 3: STROBE (`ld`)
  - cycle 4: RELEASE
  - cycle 5: DONE
- Back-to-back moves (start in the DONE cycle) have a period of SETTLE+HOLD+2 cycles.
- Phase counter width is $clog2(max(SETTLE,HOLD)+1). The counter is cleared on every state entry.

## Structure
- Package `relay_bus_pkg` holds:
  - `N`, `NREG`
  - `reg_idx_t` enum: REG_A=0, REG_B, REG_C, REG_D, REG_M1, REG_M2, REG_X, REG_Y
  - `mov_state_t` enum for the five states
- Sub-module `bus_phase_timer`:
  - Inputs: load value and enable.
  - Output: terminal-count flag.
  - Used for both the SELECT and RELEASE durations.
- One-hot decode of the latched indices stays inline.

## Test plan
- Defaults, `src_data[REG_B]`=8'hA5, start with src=B, dst=C:
  - `sel[1]`=1 and `bus_data`=A5 for cycles 1–4.
  - `ld[2]`=1 only in cycle 3.
  - `done`=1 in cycle 5.
  - All outputs 0 in cycle 6.
- Change `src_data[B]` to 8'h3C in cycle 2 of that move: `bus_data` stays A5 for the whole move.
- Hold `start` high through a move, with src=A, dst=D: moves are accepted at cycles 0 and 5, and the second `sel` rises at cycle 6.
- Assert `rst_n`=0 at cycle 2 of a move, release it at cycle 3: every output is 0 from cycle 3 on, and no `ld` or `done` pulse ever appears.
- Build with SETTLE=1, HOLD=0, src=dst=X, data 8'hFF:
  - `sel[6]`=1 in cycles 1–2.
  - `sel[6]`=1 and `ld[6]`=1 together in cycle 2.
  - `done` in cycle 3.
- Pulse `start` in cycles 2 and 3 of an active move: both pulses are ignored, exactly one `done` is produced, and it occurs in cycle 5.
